// File: rtl/pipe_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request,
// IF/ID register, one-entry hold buffer and delayed-branch redirect.
module pipe_fetch_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [7:0]  bpc,
  input  logic [7:0]  jpc,
  input  logic [31:0] da,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [7:0]  pc,
  output logic        id_valid,
  output logic [31:0] id_ins,
  output logic [7:0]  id_pc4,
  output logic        fetch_busy
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] ins_q, ins_d;
  logic [7:0]  pc4_q, pc4_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [7:0]  hold_pc4_q, hold_pc4_d;
  logic        tgt_pend_q, tgt_pend_d;
  logic [7:0]  tgt_q, tgt_d;

  logic        ack_ok;
  logic        redir;
  logic [7:0]  tgt_raw;
  logic [7:0]  tgt_live;
  logic [7:0]  pc_inc;
  logic        unused_da;

  assign unused_da = ^da[31:8];

  // Redirect target select; word-aligned, sequential increment wraps at 256.
  always_comb begin
    tgt_raw = 8'h00;
    unique case (pcsource)
      2'd1:    tgt_raw = bpc;
      2'd2:    tgt_raw = da[7:0];
      2'd3:    tgt_raw = jpc;
      default: tgt_raw = 8'h00;
    endcase
    tgt_live = tgt_raw & 8'hFC;
    pc_inc   = pc_q + 8'd4;
    // An ack only counts against a request that was actually
    // visible on the bus the cycle before.
    ack_ok   = req_q & imem_ack;
    // The ID instruction leaves ID whenever stall is low, so this
    // condition is true at most once per ID instruction.
    redir    = valid_q & ~stall & (pcsource != 2'd0);
  end

  // Next-state, pc, IF/ID, hold buffer and pending-target logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    valid_d    = valid_q;
    ins_d      = ins_q;
    pc4_d      = pc4_q;
    hold_ins_d = hold_ins_q;
    hold_pc4_d = hold_pc4_q;
    tgt_pend_d = tgt_pend_q;
    tgt_d      = tgt_q;
    unique case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (ack_ok) begin
          if (redir) begin
            pc_d       = tgt_live;
            tgt_pend_d = 1'b0;
          end else if (tgt_pend_q) begin
            pc_d       = tgt_q;
            tgt_pend_d = 1'b0;
          end else begin
            pc_d = pc_inc;
          end
          if (stall) begin
            hold_ins_d = imem_rdata;
            hold_pc4_d = pc_inc;
            state_d    = S_HOLD;
            req_d      = 1'b0;
          end else begin
            ins_d   = imem_rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
          end
        end else begin
          // Fetch still outstanding: it becomes the delay slot,
          // the target is applied when it completes.
          if (redir) begin
            tgt_d      = tgt_live;
            tgt_pend_d = 1'b1;
          end
          if (!stall) begin
            valid_d = 1'b0;
          end
        end
      end
      S_HOLD: begin
        req_d = 1'b0;
        if (!stall) begin
          ins_d   = hold_ins_q;
          pc4_d   = hold_pc4_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
          req_d   = 1'b1;
          // The held word is the delay slot and no fetch is in
          // flight, so the target can go straight into pc.
          if (redir) begin
            pc_d = tgt_live;
          end
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= 8'h00;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      ins_q      <= 32'h0;
      pc4_q      <= 8'h00;
      hold_ins_q <= 32'h0;
      hold_pc4_q <= 8'h00;
      tgt_pend_q <= 1'b0;
      tgt_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      ins_q      <= ins_d;
      pc4_q      <= pc4_d;
      hold_ins_q <= hold_ins_d;
      hold_pc4_q <= hold_pc4_d;
      tgt_pend_q <= tgt_pend_d;
      tgt_q      <= tgt_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q[7:2];
  assign pc         = pc_q;
  assign id_valid   = valid_q;
  assign id_ins     = ins_q;
  assign id_pc4     = pc4_q;
  assign fetch_busy = (state_q == S_FETCH);

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Testbench for pipe_fetch_ctrl: directed scenarios plus a random
// run checked against an architectural delayed-branch stream model.
module tb_pipe_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pcsource;
  logic [7:0]  bpc;
  logic [7:0]  jpc;
  logic [31:0] da;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [7:0]  pc;
  logic        id_valid;
  logic [31:0] id_ins;
  logic [7:0]  id_pc4;
  logic        fetch_busy;

  int tests = 0;
  int fails = 0;

  pipe_fetch_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .da         (da),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .id_valid   (id_valid),
    .id_ins     (id_ins),
    .id_pc4     (id_pc4),
    .fetch_busy (fetch_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memw(input logic [5:0] a);
    return (32'h9E37_79B9 * {26'd0, a}) + 32'h1357_2468;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mem_step(input logic ack);
    imem_ack   = ack;
    imem_rdata = ack ? memw(imem_addr) : 32'hDEAD_BEEF;
    cyc();
    imem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    pcsource = 2'd0;
    imem_ack = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    stall      = 1'b0;
    pcsource   = 2'd0;
    bpc        = 8'h00;
    jpc        = 8'h00;
    da         = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    cyc();
    cyc();
    tests++;
    if (pc !== 8'h00) begin
      fails++; $display("FAIL reset_pc got %h want 00", pc);
    end
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL reset_req got %b want 0", imem_req);
    end
    tests++;
    if (id_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", id_valid);
    end
    tests++;
    if (id_ins !== 32'h0 || id_pc4 !== 8'h00) begin
      fails++;
      $display("FAIL reset_ifid got %h/%h want 0/0", id_ins, id_pc4);
    end
    tests++;
    if (fetch_busy !== 1'b1) begin
      fails++; $display("FAIL reset_busy got %b want 1", fetch_busy);
    end
  endtask

  task automatic test_late_ack();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_2222;
    cyc();
    imem_ack = 1'b0;
    tests++;
    if (pc !== 8'h00 || id_valid !== 1'b0) begin
      fails++;
      $display("FAIL late_ack got pc %h v %b want 00 0", pc, id_valid);
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd0) begin
      fails++;
      $display("FAIL late_ack_req got %b %h want 1 00",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    cyc();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd0 || pc !== 8'h00) begin
      fails++;
      $display("FAIL first_req got %b %h %h want 1 00 00",
               imem_req, imem_addr, pc);
    end
    mem_step(1'b1);
    tests++;
    if (pc !== 8'h04 || id_pc4 !== 8'h04 || id_valid !== 1'b1) begin
      fails++;
      $display("FAIL zw_1 got %h %h %b want 04 04 1", pc, id_pc4, id_valid);
    end
    tests++;
    if (id_ins !== memw(6'd0)) begin
      fails++; $display("FAIL zw_ins0 got %h want %h", id_ins, memw(6'd0));
    end
    mem_step(1'b1);
    tests++;
    if (pc !== 8'h08 || id_pc4 !== 8'h08 || id_valid !== 1'b1) begin
      fails++;
      $display("FAIL zw_2 got %h %h %b want 08 08 1", pc, id_pc4, id_valid);
    end
    tests++;
    if (id_ins !== memw(6'd1) || imem_req !== 1'b1) begin
      fails++; $display("FAIL zw_ins1 got %h want %h", id_ins, memw(6'd1));
    end
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 3; k++) begin
      mem_step(1'b0);
      tests++;
      if (imem_addr !== 6'd2 || imem_req !== 1'b1 || id_valid !== 1'b0) begin
        fails++;
        $display("FAIL wait_%0d got %h %b %b want 02 1 0",
                 k, imem_addr, imem_req, id_valid);
      end
    end
    mem_step(1'b1);
    tests++;
    if (pc !== 8'h0C || id_pc4 !== 8'h0C || id_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_done got %h %h %b want 0c 0c 1",
               pc, id_pc4, id_valid);
    end
  endtask

  task automatic test_branch();
    do_reset();
    cyc();
    repeat (3) mem_step(1'b1);
    tests++;
    if (id_pc4 !== 8'h0C || pc !== 8'h0C) begin
      fails++; $display("FAIL br_setup got %h %h want 0c 0c", id_pc4, pc);
    end
    pcsource = 2'd1;
    bpc      = 8'h42;
    mem_step(1'b0);
    pcsource = 2'd0;
    tests++;
    if (pc !== 8'h0C || id_valid !== 1'b0) begin
      fails++; $display("FAIL br_wait got %h %b want 0c 0", pc, id_valid);
    end
    mem_step(1'b1);
    tests++;
    if (id_pc4 !== 8'h10 || id_ins !== memw(6'd3) || id_valid !== 1'b1) begin
      fails++;
      $display("FAIL br_slot got %h %h want 10 %h", id_pc4, id_ins,
               memw(6'd3));
    end
    tests++;
    if (imem_addr !== 6'h10 || pc !== 8'h40) begin
      fails++; $display("FAIL br_tgt got %h %h want 10 40", imem_addr, pc);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    cyc();
    repeat (4) mem_step(1'b1);
    stall = 1'b1;
    mem_step(1'b1);
    tests++;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_req got %b %b want 0 0", imem_req, fetch_busy);
    end
    tests++;
    if (id_pc4 !== 8'h10 || pc !== 8'h14) begin
      fails++; $display("FAIL hold_ifid got %h %h want 10 14", id_pc4, pc);
    end
    mem_step(1'b0);
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL hold_keep got %b want 0", imem_req);
    end
    stall = 1'b0;
    mem_step(1'b0);
    tests++;
    if (id_ins !== memw(6'd4) || id_pc4 !== 8'h14 || id_valid !== 1'b1) begin
      fails++;
      $display("FAIL hold_rel got %h %h want %h 14", id_ins, id_pc4,
               memw(6'd4));
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd5) begin
      fails++;
      $display("FAIL hold_next got %b %h want 1 05", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_jr();
    do_reset();
    cyc();
    mem_step(1'b1);
    pcsource = 2'd3;
    jpc      = 8'hFC;
    mem_step(1'b1);
    pcsource = 2'd0;
    tests++;
    if (pc !== 8'hFC || id_pc4 !== 8'h08) begin
      fails++; $display("FAIL jmp got %h %h want fc 08", pc, id_pc4);
    end
    mem_step(1'b1);
    tests++;
    if (pc !== 8'h00 || id_pc4 !== 8'h00) begin
      fails++; $display("FAIL wrap got %h %h want 00 00", pc, id_pc4);
    end
    pcsource = 2'd2;
    da       = 32'h1234_5677;
    mem_step(1'b1);
    pcsource = 2'd0;
    tests++;
    if (pc !== 8'h74 || imem_addr !== 6'h1D || id_pc4 !== 8'h04) begin
      fails++;
      $display("FAIL jr got %h %h %h want 74 1d 04", pc, imem_addr, id_pc4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc();
    mem_step(1'b1);
    pcsource = 2'd3;
    jpc      = 8'h20;
    mem_step(1'b1);
    pcsource = 2'd0;
    mem_step(1'b0);
    tests++;
    if (pc !== 8'h20 || imem_req !== 1'b1) begin
      fails++; $display("FAIL rm_setup got %h %b want 20 1", pc, imem_req);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests++;
      if (pc !== 8'h00 || id_valid !== 1'b0 || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL rm_%0d got %h %b %b want 00 0 0",
                 k, pc, id_valid, imem_req);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] head;
    logic [7:0] nxt;
    logic [7:0] t;
    logic [7:0] exp4;
    logic       s;
    logic       a;
    logic [1:0] ps;
    logic       prev_req;
    logic       prev_ack;
    logic [5:0] prev_addr;
    int         consumed;
    do_reset();
    cyc();
    head      = 8'h00;
    nxt       = 8'h04;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 6'd0;
    consumed  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_req && !prev_ack) begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          fails++;
          $display("FAIL rnd_stable c%0d got %b %h want 1 %h",
                   i, imem_req, imem_addr, prev_addr);
        end
      end
      s   = ($urandom_range(0, 9) < 3);
      ps  = 2'($urandom_range(0, 3));
      bpc = 8'($urandom);
      jpc = 8'($urandom);
      da  = $urandom;
      a   = imem_req && ($urandom_range(0, 1) == 1);
      if (id_valid === 1'b1 && !s) begin
        exp4 = head + 8'd4;
        tests++;
        if (id_pc4 !== exp4 || id_ins !== memw(head[7:2])) begin
          fails++;
          $display("FAIL rnd_id c%0d got %h %h want %h %h",
                   i, id_pc4, id_ins, exp4, memw(head[7:2]));
        end
        consumed++;
        case (ps)
          2'd1:    t = bpc & 8'hFC;
          2'd2:    t = da[7:0] & 8'hFC;
          2'd3:    t = jpc & 8'hFC;
          default: t = nxt + 8'd4;
        endcase
        head = nxt;
        nxt  = t;
      end
      prev_req  = imem_req;
      prev_ack  = a;
      prev_addr = imem_addr;
      stall     = s;
      pcsource  = ps;
      mem_step(a);
    end
    stall    = 1'b0;
    pcsource = 2'd0;
    tests++;
    if (consumed < 300) begin
      fails++; $display("FAIL rnd_progress got %0d want >=300", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_late_ack();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_stall_hold();
    test_wrap_jr();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_ctrl.md
PIPE_FETCH_CTRL -- requirements
Module: pipe_fetch_ctrl

Interface
REQ-001 clock  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 stall  in  1  ID-stage hold from hazard unit; 1 = IF/ID contents must not advance.
REQ-004 pcsource  in  2  redirect select from ID: 0 = sequential, 1 = bpc, 2 = da[7:0], 3 = jpc.
REQ-005 bpc  in  8  branch target byte address.
REQ-006 jpc  in  8  jump target byte address.
REQ-007 da  in  32  register-jump operand; only da[7:0] used.
REQ-008 imem_req  out  1  instruction-memory read request, level, held until ack.
REQ-009 imem_addr  out  6  word address = pc[7:2].
REQ-010 imem_ack  in  1  1-cycle pulse: imem_rdata valid this cycle, request complete.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 pc  out  8  address of the fetch in progress.
REQ-013 id_valid  out  1  IF/ID holds a real instruction.
REQ-014 id_ins  out  32  IF/ID instruction.
REQ-015 id_pc4  out  8  IF/ID instruction address + 4.
REQ-016 fetch_busy  out  1  1 in FETCH state.

Function
REQ-017 FSM states SHALL be FETCH (imem_req=1, waiting ack) and HOLD (word captured, ID stalled, imem_req=0).
REQ-018 FETCH -> FETCH on ack with stall=0: IF/ID loads {imem_rdata, pc+4}, id_valid=1, pc advances per REQ-021, new request next cycle.
REQ-019 FETCH -> HOLD on ack with stall=1: word and pc+4 SHALL be captured into a one-entry hold buffer; pc advances per REQ-021; IF/ID unchanged.
REQ-020 HOLD -> FETCH on first cycle stall=0: IF/ID loads hold buffer, id_valid=1; no imem_req while in HOLD.
REQ-021 Next pc SHALL be: live redirect target if redirect accepted same cycle; else latched target if tgt_pend=1 (tgt_pend then cleared); else pc+4.
REQ-022 Redirect accepted only when id_valid=1 and stall=0 and pcsource!=0; sampled once per ID instruction.
REQ-023 Redirect accepted while no ack this cycle SHALL latch target into tgt_reg and set tgt_pend; the fetch in progress completes and enters ID (delay slot, never squashed).
REQ-024 Target low two bits SHALL be forced to 00; pc+4 SHALL wrap modulo 256 (0xFC -> 0x00).
REQ-025 In FETCH with no ack: if stall=0, id_valid SHALL drop to 0 (bubble); if stall=1, IF/ID holds.
REQ-026 imem_addr and pc SHALL be stable for the whole request; they change only in the cycle after ack.
REQ-027 A second accepted redirect while tgt_pend=1 SHALL overwrite tgt_reg (last wins).
REQ-028 Combinational paths imem_ack->imem_req and pcsource->outputs SHALL not exist; all outputs registered.

Reset
REQ-029 While reset=1: pc=0x00, state=FETCH, imem_req=0, id_valid=0, id_ins=0, id_pc4=0, tgt_pend=0, hold buffer cleared.
REQ-030 First cycle after reset deasserts: imem_req=1, imem_addr=0.
REQ-031 reset mid-request SHALL abandon the request; a late ack after reset release with no prior cycle of imem_req=1 SHALL be ignored.

Verification
REQ-032 Zero-wait sequential: ack every cycle req=1, stall=0 -> pc 0x00,0x04,0x08; id_pc4 0x04,0x08 one cycle after each ack; id_valid=1 continuous.
REQ-033 Wait states: ack delayed 3 cycles -> imem_addr constant 3 cycles, id_valid=0 bubbles, pc increments once.
REQ-034 Branch with delay slot: ID valid at 0x08, pcsource=1, bpc=0x40, fetch of 0x0C pending -> 0x0C enters ID, next imem_addr=0x10 (0x40>>2).
REQ-035 Stall on ack: stall=1 at ack of 0x10 -> HOLD, imem_req=0; stall released -> id_ins=word at 0x10, then fetch 0x14.
REQ-036 Wrap and jr: pc=0xFC sequential -> next pc 0x00; pcsource=2, da=0x12345677 -> target 0x74.
REQ-037 Reset during wait: reset asserted mid-FETCH at pc=0x20 -> pc=0x00, id_valid=0, imem_req=0 while reset=1.
